leddisp_scan: RTL

Parametrised multiplexed 7-segment LED driver: time-multiplexes DIGITS common-anode digits, with per-slot ghost-guard blanking, 4-bit PWM brightness and optional per-digit blink. It sits between the display data registers and the board's active-low segment and anode pins. It supersedes the fixed 4-digit scanner for boards with wider displays or dimming requirements.

---
 rtl/leddisp_scan.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/leddisp_scan.sv
// leddisp_scan: multiplexed common-anode 7-segment driver with per-slot ghost
// guard, 4-bit PWM brightness and optional per-digit blink (LEDDISP_BLINK_EN).
// Ports: CLK, RST (async, active high); DIG[4*DIGITS] hex nibbles, DP/EN/BLINK
// per-digit bits, BRIGHT[4] level; nSEG {dp,g..a} and nAN active low, FRAME
// one-cycle pulse at the end of each full scan.
module leddisp_scan #(
    parameter int DIGITS       = 8,
    parameter int SUB_CYC      = 6250,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   DIG,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     EN,
    input  logic [3:0]            BRIGHT,
    input  logic [DIGITS-1:0]     BLINK,
    output logic [7:0]            nSEG,
    output logic [DIGITS-1:0]     nAN,
    output logic                  FRAME
);

    localparam int SCW = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int IW  = $clog2(DIGITS);
    localparam logic [SCW-1:0] SC_MAX  = SCW'(SUB_CYC - 1);
    localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);

    logic [SCW-1:0]    sc;
    logic [3:0]        ss;
    logic [IW-1:0]     idx;
    logic [3:0]        bright_l;
    logic [3:0]        dig_l;
    logic              dp_l;
    logic              en_l;
    logic              sc_wrap;
    logic              ss_wrap;
    logic              frame_end;
    logic              slot_start;
    logic              blinkoff;
    logic              lit;
    logic [6:0]        segdec;
    logic [DIGITS-1:0] an_d;
    logic [7:0]        seg_d;

    // Counter state (sc,ss) = (0,0) marks the first cycle of a slot; idx has
    // already advanced to the new digit, so the latches sample that digit.
    always_comb begin
        sc_wrap    = (sc == SC_MAX);
        ss_wrap    = sc_wrap && (ss == 4'hF);
        frame_end  = ss_wrap && (idx == IDX_MAX);
        slot_start = (sc == '0) && (ss == 4'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sc  <= '0;
            ss  <= 4'd0;
            idx <= '0;
        end else begin
            sc <= sc_wrap ? '0 : sc + 1'b1;
            if (sc_wrap)
                ss <= ss + 1'b1;
            if (ss_wrap)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bright_l <= 4'd0;
            dig_l    <= 4'd0;
            dp_l     <= 1'b0;
            en_l     <= 1'b0;
        end else if (slot_start) begin
            bright_l <= BRIGHT;
            dig_l    <= DIG[{idx, 2'b00} +: 4];
            dp_l     <= DP[idx];
            en_l     <= EN[idx];
        end
    end

`ifdef LEDDISP_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] F_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          phase;
    logic          blink_l;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fcnt    <= '0;
            phase   <= 1'b0;
            blink_l <= 1'b0;
        end else begin
            if (slot_start)
                blink_l <= BLINK[idx];
            if (frame_end) begin
                if (fcnt == F_MAX) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    assign blinkoff = blink_l & phase;
`else
    logic unused_blink;
    assign unused_blink = ^BLINK;
    assign blinkoff     = 1'b0;
`endif

    always_comb begin
        segdec = 7'h7F;
        case (dig_l)
            4'h0: segdec = 7'b1000000;
            4'h1: segdec = 7'b1111001;
            4'h2: segdec = 7'b0100100;
            4'h3: segdec = 7'b0110000;
            4'h4: segdec = 7'b0011001;
            4'h5: segdec = 7'b0010010;
            4'h6: segdec = 7'b0000010;
            4'h7: segdec = 7'b1111000;
            4'h8: segdec = 7'b0000000;
            4'h9: segdec = 7'b0010000;
            4'hA: segdec = 7'b0001000;
            4'hB: segdec = 7'b0000011;
            4'hC: segdec = 7'b1000110;
            4'hD: segdec = 7'b0100001;
            4'hE: segdec = 7'b0000110;
            4'hF: segdec = 7'b0001110;
            default: segdec = 7'h7F;
        endcase
    end

    // Subslot 0 is always dark so the anode switch never overlaps old data.
    always_comb begin
        lit   = (ss != 4'd0) && (ss <= bright_l) && !blinkoff;
        an_d  = '1;
        seg_d = 8'hFF;
        if (lit) begin
            an_d  = ~(DIGITS'(1) << idx);
            seg_d = {~dp_l, en_l ? segdec : 7'h7F};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nAN   <= '1;
            nSEG  <= 8'hFF;
            FRAME <= 1'b0;
        end else begin
            nAN   <= an_d;
            nSEG  <= seg_d;
            FRAME <= frame_end;
        end
    end

endmodule
